// File: rtl/i2s_tx.sv
// I2S / left-justified stereo DAC transmitter with a one-entry holding buffer and clock-enable BCK divider.
// Optional feature macro: I2S_TX_LJ_EN selects left-justified framing (MSB on the lrck edge, lrck=1 for left).
module i2s_tx #(
    parameter int DATA_W  = 16,
    parameter int SLOT_W  = 32,
    parameter int BCK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bck,
    output logic              lrck,
    output logic              din,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);
`ifdef I2S_TX_LJ_EN
    localparam logic [CNT_W-1:0] LOAD_AT  = '0;
`else
    localparam logic [CNT_W-1:0] LOAD_AT  = CNT_W'(1);
`endif

    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shifter;
    logic [FRAME_W-1:0] frame_word;
    logic [DATA_W-1:0]  hold_left;
    logic [DATA_W-1:0]  hold_right;
    logic               hold_full;
    logic               tick;
    logic               fall;
    logic               load;
    logic               lrck_next;

    assign tick    = (div_cnt == DIV_LAST);
    assign fall    = tick & bck;
    assign load    = fall & (bit_cnt == LOAD_AT);
    assign s_ready = ~hold_full;

    // Each sample sits MSB-first at the top of its slot; the zero padding falls out of the shift.
    assign frame_word = hold_full
        ? ((FRAME_W'(hold_left) << (FRAME_W - DATA_W)) | (FRAME_W'(hold_right) << (SLOT_W - DATA_W)))
        : '0;

`ifdef I2S_TX_LJ_EN
    assign lrck_next = (bit_cnt < SLOT_CNT);
`else
    assign lrck_next = (bit_cnt >= SLOT_CNT);
`endif

    // NOTE: every register here updates with <= so all of them see the same pre-edge values of
    // tick/fall/load; blocking assignments would let later statements observe half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shifter     <= '0;
            bck         <= 1'b0;
            lrck        <= 1'b0;
            din         <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            hold_full   <= 1'b0;
            // NOTE: the buffered sample is cleared too, so nothing stale can reach the pins after reset.
            hold_left   <= '0;
            hold_right  <= '0;
        end else begin
            frame_start <= load;
            underrun    <= load & ~hold_full;

            if (tick) begin
                div_cnt <= '0;
                bck     <= ~bck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall) begin
                bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
                lrck    <= lrck_next;
                if (load) begin
                    din     <= frame_word[FRAME_W-1];
                    shifter <= frame_word << 1;
                end else begin
                    din     <= shifter[FRAME_W-1];
                    shifter <= shifter << 1;
                end
            end

            // A load only drains a full buffer and a transfer only fills an empty one, so they never collide.
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (s_valid && !hold_full) begin
                hold_full  <= 1'b1;
                hold_left  <= s_left;
                hold_right <= s_right;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a 16/16/2 instance for framing, underrun, back-pressure and reset,
// and a 24/32/2 instance for slot padding. Expectations follow the I2S_TX_LJ_EN setting.
module tb_i2s_tx;

`ifdef I2S_TX_LJ_EN
    localparam logic [31:0] LR_A       = 32'hFFFF_0000;
    localparam int          FIRST_LOAD = 4;
`else
    localparam logic [31:0] LR_A       = 32'h0001_FFFE;
    localparam int          FIRST_LOAD = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] a_left, a_right;
    logic        a_valid;
    logic        a_ready, a_bck, a_lrck, a_din, a_fs, a_ur;

    logic [23:0] p_left, p_right;
    logic        p_valid;
    logic        p_ready, p_bck, p_lrck, p_din, p_fs, p_ur;

    logic        sel;
    logic        m_fs, m_ur, m_bck, m_din, m_lrck;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2s_tx #(.DATA_W(16), .SLOT_W(16), .BCK_DIV(2)) u_dut (
        .clk(clk), .rst(rst), .s_left(a_left), .s_right(a_right), .s_valid(a_valid),
        .s_ready(a_ready), .bck(a_bck), .lrck(a_lrck), .din(a_din),
        .frame_start(a_fs), .underrun(a_ur)
    );

    i2s_tx #(.DATA_W(24), .SLOT_W(32), .BCK_DIV(2)) u_pad (
        .clk(clk), .rst(rst), .s_left(p_left), .s_right(p_right), .s_valid(p_valid),
        .s_ready(p_ready), .bck(p_bck), .lrck(p_lrck), .din(p_din),
        .frame_start(p_fs), .underrun(p_ur)
    );

    assign m_fs   = sel ? p_fs   : a_fs;
    assign m_ur   = sel ? p_ur   : a_ur;
    assign m_bck  = sel ? p_bck  : a_bck;
    assign m_din  = sel ? p_din  : a_din;
    assign m_lrck = sel ? p_lrck : a_lrck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts negedges until frame_start is seen; -1 if the budget runs out.
    task automatic wait_fs(input int budget, output int cycles);
        int c;
        c = 0;
        cycles = -1;
        while (c < budget) begin
            @(negedge clk);
            c++;
            if (m_fs) begin
                cycles = c;
                return;
            end
        end
    endtask

    // Waits for the next load, then records din/lrck on each of the following nbits bck rises.
    task automatic collect(input int nbits, output logic [63:0] data, output logic [63:0] lr,
                           output logic uflag, output logic ok);
        int   cyc;
        int   n;
        logic prev;
        data  = '0;
        lr    = '0;
        uflag = 1'bx;
        ok    = 1'b0;
        wait_fs(600, cyc);
        if (cyc < 0) return;
        uflag = m_ur;
        prev  = m_bck;
        n     = 0;
        cyc   = 0;
        while (n < nbits && cyc < 8 * nbits) begin
            @(negedge clk);
            cyc++;
            if (m_bck && !prev) begin
                data = {data[62:0], m_din};
                lr   = {lr[62:0], m_lrck};
                n++;
            end
            prev = m_bck;
        end
        ok = (n == nbits);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [63:0] d, lr;
        logic        uf, ok;
        int          sent, guard;
        logic        prev_ready;
        logic [15:0] cnt;

        sel = 1'b0;
        a_valid = 1'b0; a_left = '0; a_right = '0;
        p_valid = 1'b0; p_left = '0; p_right = '0;

        // Power-on reset and first-frame timing.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", {a_bck, a_lrck, a_din, a_fs, a_ur, a_ready}, 6'b000001);
        rst = 1'b0;
        wait_fs(50, cyc);
        check("first_load_latency", cyc, FIRST_LOAD);
        check("first_underrun", a_ur, 1'b1);

        // Idle input: mute frames every 128 clk cycles.
        wait_fs(200, cyc);
        check("underrun_period", cyc, 128);
        check("underrun_pulse", a_ur, 1'b1);
        collect(32, d, lr, uf, ok);
        check("mute_done", ok, 1'b1);
        check("mute_underrun", uf, 1'b1);
        check("mute_din_zero", d[31:0], 32'h0);

        // Basic frame.
        wait_fs(200, cyc);
        check("pre_basic_ready", a_ready, 1'b1);
        a_left = 16'hA5F0; a_right = 16'h0F3C; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; a_left = 16'hDEAD; a_right = 16'hBEEF;
        check("ready_low_after_xfer", a_ready, 1'b0);
        collect(32, d, lr, uf, ok);
        check("basic_done", ok, 1'b1);
        check("basic_no_underrun", uf, 1'b0);
        check("basic_data", d[31:0], 32'hA5F0_0F3C);
        check("basic_lrck", lr[31:0], LR_A);
        check("ready_after_load", a_ready, 1'b1);
        wait_fs(200, cyc);
        check("underrun_after_single", a_ur, 1'b1);

        // Back-pressure: ten back-to-back frames from a counter.
        cnt = 16'd1; sent = 0; guard = 0;
        fork
            begin
                a_left = cnt; a_right = cnt ^ 16'h8000; a_valid = 1'b1;
                while (sent < 10 && guard < 3000) begin
                    prev_ready = a_ready;
                    @(negedge clk);
                    guard++;
                    if (prev_ready) begin
                        sent++;
                        cnt = cnt + 16'd1;
                        a_left = cnt; a_right = cnt ^ 16'h8000;
                    end
                end
                a_valid = 1'b0;
            end
            begin
                for (int f = 1; f <= 10; f++) begin
                    collect(32, d, lr, uf, ok);
                    check("bp_done", ok, 1'b1);
                    check("bp_no_underrun", uf, 1'b0);
                    check("bp_data", d[31:0], {16'(f), 16'(f) ^ 16'h8000});
                end
            end
        join
        check("bp_sent_count", sent, 10);

        // Reset mid-frame with the buffer full.
        wait_fs(200, cyc);
        a_left = 16'h1234; a_right = 16'h5678; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        check("buffer_full", a_ready, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_rst_outputs", {a_bck, a_lrck, a_din, a_fs, a_ur, a_ready}, 6'b000001);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_fs(50, cyc);
        check("rst_load_latency", cyc, FIRST_LOAD);
        check("rst_discards_buffer", a_ur, 1'b1);

        // Slot padding on the 24/32 instance.
        sel = 1'b1;
        wait_fs(600, cyc);
        check("pad_ready", p_ready, 1'b1);
        p_left = 24'h800001; p_right = 24'h123456; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        collect(64, d, lr, uf, ok);
        check("pad_done", ok, 1'b1);
        check("pad_no_underrun", uf, 1'b0);
        check("pad_left_slot", d[63:32], 32'h8000_0100);
        check("pad_right_slot", d[31:0], 32'h1234_5600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Parametrised single-clock I2S / left-justified transmitter, successor to the fixed 16-bit PCM5102 driver. It takes stereo PCM frames through a valid/ready handshake into a one-entry holding buffer and serialises them MSB-first onto BCK/LRCK/DIN. The sample width, slot width and bit-clock divider are configurable. BCK and LRCK are generated as registered outputs from a clock-enable divider, with no derived clocks. Underrun is detected and muted. The block sits between the synth/mixer sample path and the external DAC pins.

## Interface
- DATA_W, 16: PCM sample width per channel, 8..32.
- SLOT_W, 32: BCK periods per channel slot, SLOT_W >= DATA_W.
- BCK_DIV, 16: clk cycles per BCK half-period, >= 1.

- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample.
- s_valid  in  1  frame on s_left/s_right is valid.
- s_ready  out  1  holding buffer empty; a transfer occurs when s_valid & s_ready.
- bck  out  1  bit clock to DAC.
- lrck  out  1  word select to DAC.
- din  out  1  serial data to DAC.
- frame_start  out  1  one-cycle pulse when a frame is loaded into the shifter.
- underrun  out  1  one-cycle pulse when a load found the holding buffer empty.

## Operation
- Reset values (cycle after rst sampled high):
  - bck=0, lrck=0, din=0, frame_start=0, underrun=0, s_ready=1.
  - Divider, bit counter, shifter and holding buffer are all cleared.
  - A reset applied mid-frame discards any buffered sample.
- Divider:
  - div_cnt counts 0..BCK_DIV-1. At the terminal count bck toggles.
  - A terminal count with bck=1 is a "fall event".
- Bit counter:
  - bit_cnt runs 0..2*SLOT_W-1, increments once per fall event and wraps to 0.
- Outputs at a fall event (registered in the same cycle as bck falls):
  - lrck = (bit_cnt >= SLOT_W), so 0 = left in I2S mode.
  - din = frame bit delayed by one BCK (standard I2S). The left MSB appears at the fall event where bit_cnt==1. The last right bit appears at bit_cnt==0 of the following frame.
- Frame layout, MSB first:
  - Left slot: left[DATA_W-1:0], then SLOT_W-DATA_W zeros.
  - Right slot: right[DATA_W-1:0], then SLOT_W-DATA_W zeros.
- Load event (fall event with bit_cnt==1):
  - If the holding buffer is full, its contents move to the shifter and the buffer empties. s_ready is 1 from the next cycle.
  - If the buffer is empty, the shifter loads all zeros (mute) and underrun pulses.
  - frame_start pulses in every load cycle.
- Handshake rules:
  - s_ready = ~hold_full, driven from a register.
  - A transfer in the same cycle as a load with an empty buffer does not rescue that frame. The load still underruns, and the transferred sample goes out in the next frame.
  - s_left and s_right are captured only on a transfer; they may change freely otherwise.
- Arithmetic:
  - Counters are unsigned and wrap naturally.
  - No saturation or sign handling; samples are passed bit-exact.

## Timing
- BCK period = 2*BCK_DIV clk cycles. Frame = 2*SLOT_W BCK periods.
  - Fs = f_clk / (4*BCK_DIV*SLOT_W). Example: 100 MHz, BCK_DIV=16, SLOT_W=32 gives 48.83 kHz.
- After reset release: first bck rise at clk cycle BCK_DIV, first fall event at cycle 2*BCK_DIV, first load at the second fall event.
- din and lrck change only on bck falling edges. They are stable for a full BCK period around each rising edge.
- Transfer latency: a sample accepted before load N is output starting at load N. It occupies the DAC pins for exactly one frame.
- Throughput: at most one transfer per frame. s_ready is low from a transfer until the next load.

## Configuration
- I2S_TX_LJ_EN defined: left-justified format.
  - No one-bit delay. The left MSB appears at bit_cnt==0, and the load event is the fall event with bit_cnt==0.
  - lrck = (bit_cnt < SLOT_W), so 1 = left.
- I2S_TX_LJ_EN undefined: standard I2S as described above.

## Test plan
- Reset: assert rst 3 cycles mid-frame with the buffer full. Next cycle: all outputs 0, s_ready=1. The first frame after release underruns.
- Basic I2S (DATA_W=16, SLOT_W=16, BCK_DIV=2): send left=16'hA5F0, right=16'h0F3C. Sampling din on bck rises recovers A5F0 starting one BCK after lrck falls, and 0F3C starting one BCK after lrck rises.
- Underrun: no s_valid. underrun and frame_start pulse together every 128 clk cycles (16/16/2 configuration), and din stays 0.
- Back-pressure: hold s_valid=1 with an incrementing counter on both channels for 10 frames. Every value appears exactly once, in order, with no underrun after the first frame.
- Padding (DATA_W=24, SLOT_W=32): send left=24'h800001. din shows 1, 22 zeros, 1, then 8 zeros in the left slot.
- With I2S_TX_LJ_EN: same as the basic I2S test. The MSB is aligned to the lrck edge, and lrck=1 during the left slot.
